des_fila_ctrl: RTL and testbench

Transfer controller between the serial deserializer and the 8-entry word queue (fila), clocked in the queue's clk_10KHz domain. It runs the deserializer's level handshake (data_ready/ack) and moves each completed byte into the queue with a single enqueue pulse. It schedules user dequeue requests onto the same queue port, so enqueue and dequeue never happen in the same cycle. It also stalls on queue full and flags a stuck handshake.

---
 rtl/des_fila_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_des_fila_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_fila_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : des_fila_ctrl
//  Description : Transfer controller between the serial deserializer and the
//                8-entry word queue (fila), running in the queue's clk_10KHz
//                domain. Runs the data_ready/ack level handshake, moves each
//                completed byte into the queue with a one-cycle enqueue
//                strobe, and arbitrates user dequeue requests onto the same
//                queue port so enqueue and dequeue never coincide. Stalls
//                while the queue is full and flags a stuck handshake.
//
//  Ports       : clk_10KHz       - sole clock, rising edge
//                reset           - synchronous, active-high
//                data_ready      - deserializer word ready (async level)
//                des_data[7:0]   - deserializer word, stable while data_ready
//                dequeue_in      - user dequeue request (async level, edge=1)
//                len_in[7:0]     - current queue occupancy
//                ack_out         - handshake acknowledge to deserializer
//                enqueue_out     - one-cycle enqueue strobe to fila
//                enq_data[7:0]   - word presented to fila
//                dequeue_out     - one-cycle dequeue strobe to fila
//                full_stall      - word waiting while queue full
//                ack_timeout_err - sticky stuck-handshake flag
//                enq_count[7:0]  - words enqueued since reset (wrapping)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module des_fila_ctrl #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic       data_ready,
    input  logic [7:0] des_data,
    input  logic       dequeue_in,
    input  logic [7:0] len_in,
    output logic       ack_out,
    output logic       enqueue_out,
    output logic [7:0] enq_data,
    output logic       dequeue_out,
    output logic       full_stall,
    output logic       ack_timeout_err,
    output logic [7:0] enq_count
);

    localparam int               c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0]       c_DEPTH    = 8'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic             c_GNT_ENQ  = 1'b0;
    localparam logic             c_GNT_DEQ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Registered state
    state_t              r_state_q;
    logic                r_ready_meta_q;
    logic                r_ready_s_q;
    logic                r_deq_meta_q;
    logic                r_deq_s_q;
    logic                r_deq_prev_q;
    logic                r_deq_pend_q;
    logic                r_last_grant_q;
    logic [c_TMO_W-1:0]  r_tmo_cnt_q;
    logic                r_wait_low_q;
    logic [7:0]          r_enq_data_q;
    logic [7:0]          r_enq_count_q;
    logic                r_tmo_err_q;

    // Next-state values
    state_t              w_state_d;
    logic                w_deq_pend_d;
    logic                w_last_grant_d;
    logic [c_TMO_W-1:0]  w_tmo_cnt_d;
    logic                w_wait_low_d;
    logic [7:0]          w_enq_data_d;
    logic [7:0]          w_enq_count_d;
    logic                w_tmo_err_d;

    // Arbitration and strobe decode
    logic w_req_enq;
    logic w_req_deq;
    logic w_gnt_enq;
    logic w_gnt_deq;
    logic w_room;
    logic w_enq_strobe;
    logic w_deq_strobe;
    logic w_deq_rise;

    always_comb begin
        w_room    = (len_in < c_DEPTH);
        w_req_enq = (r_state_q == ST_ENQ);
        w_req_deq = r_deq_pend_q;
        // On contention the side that did not win the previous contention
        // is served; last_grant only moves when both sides request.
        w_gnt_enq = w_req_enq && (!w_req_deq || (r_last_grant_q == c_GNT_DEQ));
        w_gnt_deq = w_req_deq && (!w_req_enq || (r_last_grant_q == c_GNT_ENQ));
        w_enq_strobe = w_gnt_enq && w_room;
        w_deq_strobe = w_gnt_deq && (len_in != 8'd0);
        w_deq_rise   = r_deq_s_q && !r_deq_prev_q;
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_tmo_cnt_d    = r_tmo_cnt_q;
        w_wait_low_d   = r_wait_low_q;
        w_enq_data_d   = r_enq_data_q;
        w_enq_count_d  = r_enq_count_q;
        w_tmo_err_d    = r_tmo_err_q;

        // A granted request is consumed whether or not a strobe was issued
        // (empty queue); new edges while pending merge into the same request.
        w_deq_pend_d = w_deq_rise || (r_deq_pend_q && !w_gnt_deq);

        if (w_req_enq && w_req_deq) begin
            w_last_grant_d = w_gnt_enq ? c_GNT_ENQ : c_GNT_DEQ;
        end

        // After a timeout the handshake stays disarmed until data_ready
        // has been observed low, so a stuck word is not enqueued twice.
        if (!r_ready_s_q) begin
            w_wait_low_d = 1'b0;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (r_ready_s_q && !r_wait_low_q && w_room) begin
                    w_enq_data_d = des_data;
                    w_state_d    = ST_ENQ;
                end
            end
            ST_ENQ: begin
                if (w_enq_strobe) begin
                    w_enq_count_d = r_enq_count_q + 8'd1;
                    w_tmo_cnt_d   = '0;
                    w_state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!r_ready_s_q) begin
                    w_state_d = ST_IDLE;
                end else if (r_tmo_cnt_q == c_TMO_LAST) begin
                    w_tmo_err_d  = 1'b1;
                    w_wait_low_d = 1'b1;
                    w_state_d    = ST_IDLE;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_ready_meta_q <= 1'b0;
            r_ready_s_q    <= 1'b0;
            r_deq_meta_q   <= 1'b0;
            r_deq_s_q      <= 1'b0;
            r_deq_prev_q   <= 1'b0;
            r_deq_pend_q   <= 1'b0;
            r_last_grant_q <= c_GNT_DEQ;
            r_tmo_cnt_q    <= '0;
            r_wait_low_q   <= 1'b0;
            r_enq_data_q   <= 8'h00;
            r_enq_count_q  <= 8'h00;
            r_tmo_err_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ready_meta_q <= data_ready;
            r_ready_s_q    <= r_ready_meta_q;
            r_deq_meta_q   <= dequeue_in;
            r_deq_s_q      <= r_deq_meta_q;
            r_deq_prev_q   <= r_deq_s_q;
            r_deq_pend_q   <= w_deq_pend_d;
            r_last_grant_q <= w_last_grant_d;
            r_tmo_cnt_q    <= w_tmo_cnt_d;
            r_wait_low_q   <= w_wait_low_d;
            r_enq_data_q   <= w_enq_data_d;
            r_enq_count_q  <= w_enq_count_d;
            r_tmo_err_q    <= w_tmo_err_d;
        end
    end

    // Outputs depend only on registers and len_in.
    assign ack_out         = (r_state_q == ST_ACK);
    assign enqueue_out     = w_enq_strobe;
    assign dequeue_out     = w_deq_strobe;
    assign enq_data        = r_enq_data_q;
    assign full_stall      = (r_state_q == ST_IDLE) && r_ready_s_q && !r_wait_low_q && !w_room;
    assign ack_timeout_err = r_tmo_err_q;
    assign enq_count       = r_enq_count_q;

endmodule
`default_nettype wire

// File: tb/tb_des_fila_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_fila_ctrl
//  Description : Self-checking bench for des_fila_ctrl. Directed stimulus
//                pushes expected strobes into queues; a negedge monitor pops
//                and compares whenever the DUT issues a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_fila_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_ready;
    logic [7:0] des_data;
    logic       dequeue_in;
    logic [7:0] len_in;
    logic       ack_out;
    logic       enqueue_out;
    logic [7:0] enq_data;
    logic       dequeue_out;
    logic       full_stall;
    logic       ack_timeout_err;
    logic [7:0] enq_count;

    always #5 clk = ~clk;

    des_fila_ctrl #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
        .clk_10KHz       (clk),
        .reset           (reset),
        .data_ready      (data_ready),
        .des_data        (des_data),
        .dequeue_in      (dequeue_in),
        .len_in          (len_in),
        .ack_out         (ack_out),
        .enqueue_out     (enqueue_out),
        .enq_data        (enq_data),
        .dequeue_out     (dequeue_out),
        .full_stall      (full_stall),
        .ack_timeout_err (ack_timeout_err),
        .enq_count       (enq_count)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         enq_strobes = 0;
    int         deq_strobes = 0;
    int         enq_cyc = -1;
    int         deq_cyc = -1;
    logic [7:0] exp_enq[$];
    int         exp_deq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (enqueue_out === 1'b1 || dequeue_out === 1'b1)
            check("strobe_overlap", 32'(enqueue_out & dequeue_out), 0);
        if (enqueue_out === 1'b1) begin
            enq_strobes++;
            enq_cyc = cyc;
            if (exp_enq.size() == 0) check("enq_unexpected", 32'(enqueue_out), 0);
            else                     check("enq_data", 32'(enq_data), 32'(exp_enq.pop_front()));
        end
        if (dequeue_out === 1'b1) begin
            deq_strobes++;
            deq_cyc = cyc;
            if (exp_deq.size() == 0) check("deq_unexpected", 32'(dequeue_out), 0);
            else                     void'(exp_deq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic v, input int max, input string name);
        int n = 0;
        while (ack_out !== v && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ack_out), 32'(v));
    endtask

    task automatic xfer(input logic [7:0] d);
        des_data = d;
        exp_enq.push_back(d);
        data_ready = 1'b1;
        wait_ack(1'b1, 10, "xfer_ack_rise");
        data_ready = 1'b0;
        wait_ack(1'b0, 3, "xfer_ack_fall");
    endtask

    task automatic conflict(input logic [7:0] d);
        des_data = d;
        exp_enq.push_back(d);
        exp_deq.push_back(1);
        data_ready = 1'b1;
        dequeue_in = 1'b1;
        wait_ack(1'b1, 10, "conf_ack_rise");
        data_ready = 1'b0;
        dequeue_in = 1'b0;
        wait_ack(1'b0, 3, "conf_ack_fall");
        tick(3);
    endtask

    initial begin
        int d0;
        logic [7:0] w;
        reset      = 1'b1;
        data_ready = 1'b0;
        dequeue_in = 1'b0;
        des_data   = 8'h00;
        len_in     = 8'd0;
        tick(3);
        check("rst_ack",   32'(ack_out), 0);
        check("rst_enq",   32'(enqueue_out), 0);
        check("rst_deq",   32'(dequeue_out), 0);
        check("rst_data",  32'(enq_data), 0);
        check("rst_full",  32'(full_stall), 0);
        check("rst_err",   32'(ack_timeout_err), 0);
        check("rst_count", 32'(enq_count), 0);
        reset = 1'b0;
        tick(2);

        // Single word
        xfer(8'hA5);
        check("single_count",  32'(enq_count), 1);
        check("single_pulses", 32'(enq_strobes), 1);

        // Full queue stall, then release
        len_in     = 8'd8;
        des_data   = 8'h3C;
        data_ready = 1'b1;
        tick(6);
        check("full_stall_set", 32'(full_stall), 1);
        check("full_no_ack",    32'(ack_out), 0);
        check("full_no_enq",    32'(enq_strobes), 1);
        exp_enq.push_back(8'h3C);
        len_in = 8'd7;
        wait_ack(1'b1, 6, "full_release_ack");
        check("full_stall_clr", 32'(full_stall), 0);
        data_ready = 1'b0;
        wait_ack(1'b0, 3, "full_ack_fall");
        check("full_count", 32'(enq_count), 2);
        tick(2);

        // Arbitration conflicts: enqueue wins first, dequeue second
        len_in = 8'd3;
        conflict(8'h11);
        check("conf1_order", 32'(deq_cyc - enq_cyc), 1);
        conflict(8'h22);
        check("conf2_order", 32'(enq_cyc - deq_cyc), 1);
        check("conf_count",  32'(enq_count), 4);

        // Dequeue on empty queue, then two real dequeues
        len_in = 8'd0;
        d0 = deq_strobes;
        dequeue_in = 1'b1; tick(3); dequeue_in = 1'b0; tick(5);
        check("empty_deq", 32'(deq_strobes), 32'(d0));
        len_in = 8'd2;
        repeat (2) begin
            exp_deq.push_back(1);
            dequeue_in = 1'b1; tick(3); dequeue_in = 1'b0; tick(5);
        end
        check("two_deq", 32'(deq_strobes), 32'(d0 + 2));

        // Ack timeout
        len_in   = 8'd0;
        des_data = 8'h77;
        exp_enq.push_back(8'h77);
        data_ready = 1'b1;
        wait_ack(1'b1, 10, "tmo_ack_rise");
        tick(15);
        check("tmo_ack_held",  32'(ack_out), 1);
        check("tmo_err_early", 32'(ack_timeout_err), 0);
        tick(1);
        check("tmo_ack_drop",  32'(ack_out), 0);
        check("tmo_err_set",   32'(ack_timeout_err), 1);
        tick(10);
        check("tmo_no_rearm",  32'(ack_out), 0);
        check("tmo_count",     32'(enq_count), 5);
        data_ready = 1'b0;
        tick(4);
        xfer(8'h88);
        check("tmo_err_sticky", 32'(ack_timeout_err), 1);
        check("tmo_count2",     32'(enq_count), 6);

        // Reset mid-ACK with data_ready held: handshake restarts
        des_data = 8'hC3;
        exp_enq.push_back(8'hC3);
        data_ready = 1'b1;
        wait_ack(1'b1, 10, "rst_mid_ack_rise");
        reset = 1'b1;
        tick(1);
        check("mid_rst_ack",   32'(ack_out), 0);
        check("mid_rst_enq",   32'(enqueue_out), 0);
        check("mid_rst_full",  32'(full_stall), 0);
        check("mid_rst_err",   32'(ack_timeout_err), 0);
        check("mid_rst_count", 32'(enq_count), 0);
        check("mid_rst_data",  32'(enq_data), 0);
        reset = 1'b0;
        exp_enq.push_back(8'hC3);
        wait_ack(1'b1, 10, "restart_ack_rise");
        data_ready = 1'b0;
        wait_ack(1'b0, 3, "restart_ack_fall");
        check("restart_count", 32'(enq_count), 1);

        // Counter wrap: 255 more transfers make 256 since reset
        for (int i = 0; i < 255; i++) begin
            w = 8'(i) ^ 8'h5A;
            xfer(w);
        end
        check("wrap_count", 32'(enq_count), 0);

        tick(3);
        check("enq_queue_drained", 32'(exp_enq.size()), 0);
        check("deq_queue_drained", 32'(exp_deq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
